// File: rtl/ofifo_collect_if.sv
// Bus bundle for the output-side collector: per-column write side, row read side
// and the occupancy flags. The master drives data/strobes, the slave is the collector.
interface ofifo_collect_if #(
    parameter int col = 8,
    parameter int bw  = 16
);
    logic [col*bw-1:0] in;
    logic [col-1:0]    wr;
    logic              rd;
    logic [col*bw-1:0] out;
    logic              o_full;
    logic              o_ready;
    logic              o_valid;

    modport master (
        output in,
        output wr,
        output rd,
        input  out,
        input  o_full,
        input  o_ready,
        input  o_valid
    );

    modport slave (
        input  in,
        input  wr,
        input  rd,
        output out,
        output o_full,
        output o_ready,
        output o_valid
    );
endinterface

// File: rtl/ofifo_collect.sv
// Systolic-array output collector: one circular FIFO per column, written independently,
// popped as a whole aligned row. Rows are formed by per-column write order, not arrival time.
module ofifo_collect #(
    parameter int col   = 8,
    parameter int bw    = 16,
    parameter int depth = 64
) (
    input  logic             clk,
    input  logic             reset,
    ofifo_collect_if.slave   bus
);
    localparam int ptr_w = $clog2(depth) + 1;
    localparam int idx_w = ptr_w - 1;

    logic [col-1:0]    full_vec;
    logic [col-1:0]    empty_vec;
    logic [col*bw-1:0] out_bus;
    logic              any_full;
    logic              all_valid;
    logic              rd_en;

    // A row is only poppable once every column has contributed its word.
    assign any_full  = |full_vec;
    assign all_valid = ~|empty_vec;
    assign rd_en     = bus.rd & all_valid;

    assign bus.o_full  = any_full;
    assign bus.o_ready = ~any_full;
    assign bus.o_valid = all_valid;
    assign bus.out     = out_bus;

    generate
        for (genvar gi = 0; gi < col; gi++) begin : g_col
            logic [bw-1:0]    mem [depth];
            logic [ptr_w-1:0] wr_ptr_reg;
            logic [ptr_w-1:0] wr_ptr_next;
            logic [ptr_w-1:0] rd_ptr_reg;
            logic [ptr_w-1:0] rd_ptr_next;
            logic [bw-1:0]    out_reg;
            logic             wr_en;

            // Extra wrap bit distinguishes full from empty when the indices coincide.
            assign empty_vec[gi] = (wr_ptr_reg == rd_ptr_reg);
            assign full_vec[gi]  = (wr_ptr_reg[ptr_w-1] != rd_ptr_reg[ptr_w-1]) &&
                                   (wr_ptr_reg[idx_w-1:0] == rd_ptr_reg[idx_w-1:0]);
            assign wr_en         = bus.wr[gi] & ~full_vec[gi];

            always_comb begin
                wr_ptr_next = wr_ptr_reg;
                rd_ptr_next = rd_ptr_reg;
                if (wr_en) begin
                    wr_ptr_next = wr_ptr_reg + ptr_w'(1);
                end
                if (rd_en) begin
                    rd_ptr_next = rd_ptr_reg + ptr_w'(1);
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    out_reg    <= '0;
                end else begin
                    wr_ptr_reg <= wr_ptr_next;
                    rd_ptr_reg <= rd_ptr_next;
                    if (rd_en) begin
                        out_reg <= mem[rd_ptr_reg[idx_w-1:0]];
                    end
                end
            end

            // Storage is deliberately left uncleared by reset so it can map to RAM.
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[wr_ptr_reg[idx_w-1:0]] <= bus.in[bw*gi +: bw];
                end
            end

            assign out_bus[bw*gi +: bw] = out_reg;
        end
    endgenerate
endmodule

// File: doc/ofifo_collect.md
Name: ofifo_collect

Overview:
Output-side collector for the systolic array: the counterpart of the row-wise input L0 buffer. Each array column emits partial sums independently and skewed in time, so each column has a write strobe. The block holds one circular FIFO per column and re-aligns the words by order, not by arrival time. A full row (one word per column) is popped in a single read and sent toward the psum SRAM / SFU path.

Parameters:
col, 8, number of array columns, one FIFO each
bw, 16, psum word width per column
depth, 64, entries per column FIFO; must be a power of 2, at least 2
ptr_w, log2(depth)+1, pointer width including the wrap bit (derived, not overridden)

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in  input  col*bw  column j data on in[bw*(j+1)-1:bw*j]
wr  input  col  per-column write strobe; wr[j] qualifies column j slice
rd  input  1  pop one aligned row from all columns
out  output  col*bw  registered popped row, same column packing as in
o_full  output  1  high if any column FIFO is full
o_ready  output  1  equals !o_full; upstream may write while high
o_valid  output  1  high when every column FIFO holds at least one entry

Behaviour:
- Per column j: storage mem_j[depth], wr_ptr_j and rd_ptr_j, each ptr_w bits. Index is ptr[ptr_w-2:0].
- empty_j = (wr_ptr_j == rd_ptr_j).
- full_j = (MSBs differ) and (lower bits equal).
- Flags are combinational from the current pointers: o_full = OR(full_j), o_ready = !o_full, o_valid = AND(!empty_j).
- Write: at posedge, if wr[j] and !full_j (evaluated before the edge), mem_j[idx(wr_ptr_j)] <= in slice j and wr_ptr_j increments mod 2^ptr_w.
- Write to a full column: the word is dropped silently; pointer and memory are unchanged; other columns are unaffected.
- Read: at posedge, if rd and o_valid (before the edge), out slice j <= mem_j[idx(rd_ptr_j)] for all j, and every rd_ptr_j increments. The popped row is visible on out 1 cycle after the accepting edge.
- rd while !o_valid: ignored; out holds its last value; pointers unchanged.
- Columns never pop individually. Row alignment is by per-column write order: the k-th word written to each column forms row k.
- Simultaneous rd and wr[j]: both act in the same edge, judged on pre-edge state.
  - Column full and read accepted: the write is still dropped.
  - Column empty: the read cannot be accepted, since o_valid is low.
  - Column with 1 entry, rd and wr both high: occupancy stays 1 and o_valid stays high.
- Wrap-around: pointers roll over naturally; data order is preserved across the wrap with no bubble.
- Reset (reset=0), at any time including mid-traffic, takes effect immediately without waiting for clk:
  - all pointers = 0, out = 0;
  - hence o_full = 0, o_ready = 1, o_valid = 0.
  - Memory contents are not cleared.
  - After reset releases, the first usable posedge behaves as an empty FIFO.
- No X on out: out is updated only from written entries or the reset value.

Test Plan:
- Reset mid-traffic: with 5 rows buffered, drive reset=0 between edges -> o_valid=0, o_full=0, o_ready=1, out=0 immediately. After release, rd=1 is ignored and out stays 0.
- Skewed fill (col=8, bw=16): write 16'h0100+j to column j at cycle t0+j (one-hot wr shifting left) -> o_valid low until after the column-7 write edge. Then pulse rd -> next cycle out = {0107,0106,...,0100} (MSB column 7).
- Single-column overflow: 65 writes to column 3 only, value = write index -> o_full=1 and o_ready=0 after the 64th write; o_valid=0. Fill all other columns, then read 64 rows -> column 3 returns 0..63 in order; value 64 never appears.
- Read on empty: after all rows are drained, rd=1 for 3 cycles -> out holds the last row; o_valid stays 0. A subsequent full-row write followed by rd -> the correct new row appears.
- Simultaneous ops:
  - All columns full, rd=1 and wr=all-ones in the same cycle -> the row is popped, the new word is dropped, and o_full=0 after the edge.
  - All columns at 1 entry, rd=1 and wr=all-ones -> o_valid stays 1, and the next rd returns the newly written row.
- Streaming wrap: write incrementing rows (column j = 16'(k*8+j)) on every cycle for 200 cycles, with rd=1 from cycle 2 -> out sequence equals input rows 0..199 in order, 1 cycle after each accepted rd; o_full never asserts.
